// File: rtl/fpu_pkg.sv
// Shared constants, types and operand classification for the FP32 datapath.
package fpu_pkg;

  localparam int D_WIDTH = 32;
  localparam int E_WIDTH = 8;
  localparam int M_WIDTH = 23;
  localparam int BIAS    = 127;

  localparam logic [D_WIDTH-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [D_WIDTH-1:0] POS_INF = 32'h7F80_0000;

  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DIV0    = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UNF     = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CL_ZERO,
    CL_NORMAL,
    CL_INF,
    CL_NAN
  } fp_class_e;

  typedef struct packed {
    logic               sign;
    logic [E_WIDTH-1:0] exp;
    logic [M_WIDTH-1:0] man;
  } fp32_t;

  // A zero exponent is treated as zero, so denormals flush here.
  function automatic fp_class_e classify(input fp32_t x);
    if (x.exp == '0)
      return CL_ZERO;
    else if (x.exp == '1)
      return (x.man == '0) ? CL_INF : CL_NAN;
    else
      return CL_NORMAL;
  endfunction

endpackage

// File: rtl/restoring_div_core.sv
// Restoring unsigned divider: one quotient bit per clock, Q = floor(a * 2^(W) / b).
module restoring_div_core
  import fpu_pkg::*;
#(
  parameter int W = M_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W:0]   quo_o
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  div_q;
  logic [W:0]    quo_q, quo_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          ge;
  logic [W:0]    diff;

  always_comb begin
    ge    = (rem_q >= {1'b0, div_q});
    diff  = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    // diff < divisor < 2^W, so dropping its top bit before the shift is lossless.
    rem_d = {diff[W-1:0], 1'b0};
    quo_d = {quo_q[W-1:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= {1'b0, a_i};
      div_q  <= b_i;
      quo_q  <= '0;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0)
        busy_q <= 1'b0;
      else
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign done_o = busy_q && (cnt_q == '0);
  assign busy_o = busy_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/fpu_divider_seq.sv
// Iterative FP32 divider with truncating rounding and valid/ready handshakes.
module fpu_divider_seq
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] floating1_in,
  input  logic [D_WIDTH-1:0] floating2_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] floating_division_out,
  output logic [3:0]         flags
);

  state_e               state_q;
  logic                 in_ready_q, out_valid_q;
  logic [D_WIDTH-1:0]   result_q;
  logic [3:0]           flags_q;
  logic                 sign_q;
  logic [E_WIDTH-1:0]   e1_q, e2_q;

  fp32_t                f1, f2;
  fp_class_e            c1, c2;
  logic                 sign_in, accept, is_special, core_start;
  logic [D_WIDTH-1:0]   spec_res;
  logic [3:0]           spec_flags;

  logic                 core_busy, core_done;
  logic [M_WIDTH+1:0]   quo;
  logic                 adj;
  logic [M_WIDTH-1:0]   mant;
  logic signed [9:0]    e_norm;
  logic [D_WIDTH-1:0]   norm_res;
  logic [3:0]           norm_flags;

  assign f1      = fp32_t'(floating1_in);
  assign f2      = fp32_t'(floating2_in);
  assign c1      = classify(f1);
  assign c2      = classify(f2);
  assign sign_in = f1.sign ^ f2.sign;
  assign accept  = in_ready_q && in_valid;

  always_comb begin
    is_special = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (c1 == CL_NAN || c2 == CL_NAN || (c1 == CL_ZERO && c2 == CL_ZERO) ||
        (c1 == CL_INF && c2 == CL_INF)) begin
      spec_res                 = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (c1 == CL_NORMAL && c2 == CL_ZERO) begin
      spec_res              = {sign_in, POS_INF[D_WIDTH-2:0]};
      spec_flags[FLAG_DIV0] = 1'b1;
    end else if (c1 == CL_INF) begin
      spec_res = {sign_in, POS_INF[D_WIDTH-2:0]};
    end else if (c2 == CL_INF || c1 == CL_ZERO) begin
      spec_res = {sign_in, {(D_WIDTH-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  assign core_start = accept && !is_special;

  restoring_div_core #(.W(M_WIDTH + 1)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (core_start),
    .a_i     ({1'b1, f1.man}),
    .b_i     ({1'b1, f2.man}),
    .busy_o  (core_busy),
    .done_o  (core_done),
    .quo_o   (quo)
  );

  // Quotient of two [1,2) mantissas lies in (0.5,2); a clear top bit costs one exponent.
  always_comb begin
    adj        = ~quo[M_WIDTH+1];
    mant       = quo[M_WIDTH+1] ? quo[M_WIDTH:1] : quo[M_WIDTH-1:0];
    e_norm     = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127
                 - $signed({9'd0, adj});
    norm_flags = '0;
    if (e_norm >= 10'sd255) begin
      norm_res             = {sign_q, POS_INF[D_WIDTH-2:0]};
      norm_flags[FLAG_OVF] = 1'b1;
    end else if (e_norm <= 10'sd0) begin
      norm_res             = {sign_q, {(D_WIDTH-1){1'b0}}};
      norm_flags[FLAG_UNF] = 1'b1;
    end else begin
      norm_res = {sign_q, e_norm[E_WIDTH-1:0], mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            sign_q     <= sign_in;
            e1_q       <= f1.exp;
            e2_q       <= f2.exp;
            if (is_special) begin
              result_q    <= spec_res;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          if (core_done || !core_busy)
            state_q <= ST_NORM;
        end
        ST_NORM: begin
          result_q    <= norm_res;
          flags_q     <= norm_flags;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready              = in_ready_q;
  assign out_valid             = out_valid_q;
  assign floating_division_out = result_q;
  assign flags                 = flags_q;

endmodule

// File: tb/tb_fpu_divider_seq.sv
// Directed and randomised checks of the sequential FP32 divider.
module tb_fpu_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] floating1_in, floating2_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] floating_division_out;
  logic [3:0]  flags;

  int n_vec  = 0;
  int n_miss = 0;

  fpu_divider_seq dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .floating1_in          (floating1_in),
    .floating2_in          (floating2_in),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .floating_division_out (floating_division_out),
    .flags                 (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Real-number reference: mantissa ratio, normalised into [1,2), truncated to 23 bits.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    real r;
    int  ex;
    logic [22:0] m;
    r  = (1.0 + real'(a[22:0]) / 8388608.0) / (1.0 + real'(b[22:0]) / 8388608.0);
    ex = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (r < 1.0) begin
      r  = r * 2.0;
      ex = ex - 1;
    end
    m = 23'($rtoi((r - 1.0) * 8388608.0));
    return {a[31] ^ b[31], 8'(ex), m};
  endfunction

  // exp_lat counts clock edges after the accepting edge until out_valid is seen.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_flags,
                       input int exp_lat, input int hold, input bit glitch);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    floating1_in = a;
    floating2_in = b;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (glitch && lat == 5) begin
        floating1_in = 32'h7F80_0001;
        floating2_in = 32'h0000_0000;
        in_valid     = 1'b1;
      end
      if (glitch && lat == 6) in_valid = 1'b0;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, floating_division_out, exp_res);
    chk({tag, ".flags"}, {28'd0, flags}, {28'd0, exp_flags});
    chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, floating_division_out, exp_res);
      chk({tag, ".hold_flags"}, {28'd0, flags}, {28'd0, exp_flags});
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready_back"}, {31'd0, in_ready}, 32'd1);
    $display("vector %s: %h / %h -> %h flags %b lat %0d", tag, a, b,
             floating_division_out, flags, lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    floating1_in = '0;
    floating2_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", floating_division_out, 32'd0);
    chk("reset.flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("six_div_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 26, 0, 0);
    apply("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 26, 0, 0);
    apply("equal",        32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0000, 4'b0000, 26, 0, 0);
    apply("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 0, 0, 0);
    apply("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0, 0, 0);
    apply("nan_operand",  32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 0, 0, 0);
    apply("inf_div_inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 0, 0, 0);
    apply("inf_div_neg",  32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 0, 0, 0);
    apply("fin_div_inf",  32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 0, 0, 0);
    apply("negzero_div",  32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000, 0, 0, 0);
    apply("denorm_flush", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 0, 0, 0);
    apply("overflow",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 26, 0, 0);
    apply("underflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 26, 0, 0);
    apply("hold_ten",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 26, 10, 0);
    apply("busy_ignored", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 26, 0, 1);

    // Abort an operation partway through the iterations with the async reset.
    @(negedge clk);
    floating1_in = 32'h40C0_0000;
    floating2_in = 32'h4000_0000;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort.result", floating_division_out, 32'd0);
    chk("abort.flags", {28'd0, flags}, 32'd0);
    $display("vector abort: reset at iteration 10 -> out_valid %b in_ready %b",
             out_valid, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 26, 0, 0);

    for (int k = 0; k < 8; k++) begin
      ra = {1'($urandom_range(1)), 8'($urandom_range(150, 100)), 23'($urandom)};
      rb = {1'($urandom_range(1)), 8'($urandom_range(150, 100)), 23'($urandom)};
      apply($sformatf("random%0d", k), ra, rb, model(ra, rb), 4'b0000, 26, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
